// File: rtl/sprite_row_fetcher.sv
// sprite_row_fetcher: requester side of the sprite ROM read port.
// Accepts one (sprite, row) request, issues the 16 word reads for the row,
// tracks the fixed ROM latency with a valid pipe, buffers returned words in a
// credit-limited FIFO and unpacks each word into four 4-bit pixels.
module sprite_row_fetcher #(
    parameter int ROM_LATENCY = 3,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_sprite,
    input  logic [5:0]  req_row,
    output logic [2:0]  rom_sprite_sel_o,
    output logic [9:0]  rom_word_addr_o,
    input  logic [15:0] rom_data_i,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [3:0]  pix_o,
    output logic        pix_last,
    output logic        busy_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(ROM_LATENCY + 2);
    // Bit 0 is aligned with the registered address; the last bit lines up
    // with rom_data_i, ROM_LATENCY cycles later.
    localparam int PW = ROM_LATENCY + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [5:0]      row_r;
    logic [3:0]      col_r;
    logic [PW-1:0]   vpipe_r;
    logic [IW-1:0]   inflight_r;
    logic [CW-1:0]   fifo_count_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [15:0]     fifo_mem_r [FIFO_DEPTH];
    logic [1:0]      pix_idx_r;
    logic [3:0]      word_cnt_r;

    logic            accept_s;
    logic            credit_ok_s;
    logic            issue_s;
    logic            ret_s;
    logic            fire_s;
    logic            pop_s;
    logic [15:0]     wr_data_s;
    logic [15:0]     head_s;

    // Selects pixel idx of a word, most significant nibble first.
    function automatic logic [3:0] pick_nibble(input logic [15:0] w, input logic [1:0] idx);
        logic [3:0] n;
        case (idx)
            2'd0:    n = w[15:12];
            2'd1:    n = w[11:8];
            2'd2:    n = w[7:4];
            2'd3:    n = w[3:0];
            default: n = 4'd0;
        endcase
        return n;
    endfunction

    assign req_ready   = (state_r == ST_IDLE) && !rst;
    assign busy_o      = (state_r != ST_IDLE);
    assign accept_s    = req_valid && req_ready;
    // Words already buffered plus words still in the ROM must leave a free slot.
    assign credit_ok_s = (32'(fifo_count_r) + 32'(inflight_r)) < 32'(FIFO_DEPTH);
    assign issue_s     = (state_r == ST_ISSUE) && credit_ok_s;
    assign ret_s       = vpipe_r[PW-1];
    // Sprite index 7 is not a real sprite: it always reads back as transparent.
    assign wr_data_s   = (rom_sprite_sel_o == 3'd7) ? 16'd0 : rom_data_i;
    assign pix_valid   = (fifo_count_r != CW'(0));
    assign head_s      = fifo_mem_r[rd_ptr_r];
    assign fire_s      = pix_valid && pix_ready;
    assign pop_s       = fire_s && (pix_idx_r == 2'd3);
    // Gated by pix_valid so the output reads zero while the FIFO is empty or in reset.
    assign pix_o       = pix_valid ? pick_nibble(head_s, pix_idx_r) : 4'd0;
    assign pix_last    = pix_valid && (word_cnt_r == 4'd15) && (pix_idx_r == 2'd3);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: accept, issue 16 words, then wait for the last pixel.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (issue_s && (col_r == 4'd15)) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (fire_s && pix_last) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Request latch and address generation; the sprite select only moves on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_sprite_sel_o <= 3'd0;
            rom_word_addr_o  <= 10'd0;
            row_r            <= 6'd0;
            col_r            <= 4'd0;
        end else if (accept_s) begin
            rom_sprite_sel_o <= req_sprite;
            row_r            <= req_row;
            col_r            <= 4'd0;
        end else if (issue_s) begin
            rom_word_addr_o  <= {row_r, col_r};
            col_r            <= col_r + 4'd1;
        end
    end

    // Valid pipe mirroring the ROM latency, and the in-flight word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe_r    <= '0;
            inflight_r <= IW'(0);
        end else begin
            vpipe_r <= {vpipe_r[PW-2:0], issue_s};
            case ({issue_s, ret_s})
                2'b10:   inflight_r <= inflight_r + IW'(1);
                2'b01:   inflight_r <= inflight_r - IW'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // Return-word FIFO storage; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (ret_s) begin
            fifo_mem_r[wr_ptr_r] <= wr_data_s;
        end
    end

    // FIFO pointers, occupancy, pixel index and per-row word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r     <= AW'(0);
            rd_ptr_r     <= AW'(0);
            fifo_count_r <= CW'(0);
            pix_idx_r    <= 2'd0;
            word_cnt_r   <= 4'd0;
        end else begin
            if (ret_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({ret_s, pop_s})
                2'b10:   fifo_count_r <= fifo_count_r + CW'(1);
                2'b01:   fifo_count_r <= fifo_count_r - CW'(1);
                default: fifo_count_r <= fifo_count_r;
            endcase
            if (fire_s) begin
                pix_idx_r <= pix_idx_r + 2'd1;
            end
            if (accept_s) begin
                word_cnt_r <= 4'd0;
            end else if (pop_s) begin
                word_cnt_r <= word_cnt_r + 4'd1;
            end
        end
    end

    // A returning word must always find a free FIFO slot.
    fifo_no_overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(ret_s && !pop_s && (fifo_count_r == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Self-checking bench for sprite_row_fetcher: a ROM model with 3-cycle latency,
// a pixel scoreboard filled from a row-level reference model, and directed
// timing, backpressure, select-hold, reset and random-traffic scenarios.
module tb_sprite_row_fetcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_sprite;
    logic [5:0]  req_row;
    logic [2:0]  rom_sprite_sel_o;
    logic [9:0]  rom_word_addr_o;
    logic [15:0] rom_data_i;
    logic        pix_valid;
    logic        pix_ready;
    logic [3:0]  pix_o;
    logic        pix_last;
    logic        busy_o;

    typedef struct packed {
        logic [3:0] pix;
        logic       last;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_last   = 0;
    logic        rnd_ready_en = 1'b0;
    logic        ready_fixed  = 1'b1;
    logic [9:0]  rom_a1;
    logic [9:0]  rom_a2;
    logic [2:0]  rom_s2;

    sprite_row_fetcher #(.ROM_LATENCY(3), .FIFO_DEPTH(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_sprite       (req_sprite),
        .req_row          (req_row),
        .rom_sprite_sel_o (rom_sprite_sel_o),
        .rom_word_addr_o  (rom_word_addr_o),
        .rom_data_i       (rom_data_i),
        .pix_valid        (pix_valid),
        .pix_ready        (pix_ready),
        .pix_o            (pix_o),
        .pix_last         (pix_last),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    // Sprite ROM contents: an address- and sprite-dependent pattern.
    function automatic logic [15:0] rom_fn(input logic [2:0] s, input logic [9:0] a);
        logic [31:0] t;
        t = ({22'd0, a} * 32'd40503) ^ ({29'd0, s} * 32'd4951) ^ 32'h0000A5C3;
        return t[15:0] ^ t[31:16];
    endfunction

    // ROM: address in cycle n gives data in cycle n+3; select sampled one stage after address.
    always @(posedge clk) begin
        rom_a1     <= rom_word_addr_o;
        rom_a2     <= rom_a1;
        rom_s2     <= rom_sprite_sel_o;
        rom_data_i <= rom_fn(rom_s2, rom_a2);
    end

    // Downstream ready: fixed level or 50% random, updated shortly after each edge.
    always @(posedge clk) begin
        #2;
        if (rnd_ready_en) pix_ready = 1'($urandom_range(0, 1));
        else              pix_ready = ready_fixed;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: one row is 16 words, each emitted as four nibbles MSB first.
    task automatic push_row(input logic [2:0] s, input logic [5:0] r);
        logic [15:0] w;
        exp_t e;
        for (int c = 0; c < 16; c++) begin
            w = (s == 3'd7) ? 16'd0 : rom_fn(s, {r, 4'(c)});
            for (int p = 0; p < 4; p++) begin
                e.pix  = 4'(w >> (12 - 4 * p));
                e.last = (c == 15) && (p == 3);
                exp_q.push_back(e);
            end
        end
    endtask

    // Monitor: every accepted pixel is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            check("fifo_bound", 32'(dut.fifo_count_r <= 4'd8), 32'd1);
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pixel: actual pixel 0x%0h, required none", pix_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pix_value", 32'(pix_o), 32'(mon_e.pix));
                    check("pix_last", 32'(pix_last), 32'(mon_e.last));
                end
                if (pix_last) n_last++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents a request until accepted; returns #1 into the cycle after acceptance.
    task automatic do_request(input logic [2:0] s, input logic [5:0] r);
        bit done = 1'b0;
        req_valid  = 1'b1;
        req_sprite = s;
        req_row    = r;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                push_row(s, r);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        check("req_accept", 32'(done), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || busy_o) && k < 3000) begin
            tick(1);
            k++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({name, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    // One row with an ideal sink: address order and cycle-exact milestones.
    task automatic row_timing(input logic [2:0] s, input logic [5:0] r);
        logic [9:0] prev;
        logic [9:0] addrs[$];
        do_request(s, r);
        prev = rom_word_addr_o;
        for (int k = 1; k <= 70; k++) begin
            if (k >= 2 && rom_word_addr_o != prev) begin
                addrs.push_back(rom_word_addr_o);
                prev = rom_word_addr_o;
            end
            if (k == 5) check("no_valid_c5", 32'(pix_valid), 32'd0);
            if (k == 6) check("first_valid_c6", 32'(pix_valid), 32'd1);
            if (k == 69) begin
                check("last_c69", 32'(pix_last), 32'd1);
                check("ready_low_c69", 32'(req_ready), 32'd0);
            end
            if (k == 70) check("ready_back_c70", 32'(req_ready), 32'd1);
            if (k < 70) tick(1);
        end
        check("addr_count", 32'(addrs.size()), 32'd16);
        for (int i = 0; i < addrs.size(); i++) begin
            check("addr_seq", 32'(addrs[i]), 32'({r, 4'(i)}));
        end
    endtask

    initial begin
        logic [3:0] pix_hold;
        int         last0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_sprite = 3'd0;
        req_row    = 6'd0;

        // Reset state
        tick(3);
        check("rst_addr", 32'(rom_word_addr_o), 32'd0);
        check("rst_sel", 32'(rom_sprite_sel_o), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_o", 32'(pix_o), 32'd0);
        check("rst_pix_last", 32'(pix_last), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        tick(1);
        check("idle_req_ready", 32'(req_ready), 32'd1);

        // Single row, ideal sink
        row_timing(3'd2, 6'd5);
        wait_idle("single");

        // Backpressure: sink stalls for 20 cycles after the first pixel
        do_request(3'd4, 6'd33);
        tick(6);
        ready_fixed = 1'b0;
        pix_hold    = pix_o;
        for (int k = 8; k <= 26; k++) begin
            tick(1);
            check("pix_stable", 32'(pix_o), 32'(pix_hold));
            if (k == 20) check("fifo_full", 32'(dut.fifo_count_r), 32'd8);
            if (k == 15 || k == 26) check("addr_frozen", 32'(rom_word_addr_o), 32'({6'd33, 4'd7}));
        end
        tick(1);
        ready_fixed = 1'b1;
        wait_idle("backpressure");

        // Sprite-select hold while req_valid/req_sprite toggle during the burst
        do_request(3'd5, 6'd17);
        for (int k = 0; k < 300 && busy_o; k++) begin
            check("sel_hold", 32'(rom_sprite_sel_o), 32'd5);
            check("busy_not_ready", 32'(req_ready), 32'd0);
            if (exp_q.size() > 8) begin
                req_valid  = 1'($urandom_range(0, 1));
                req_sprite = 3'($urandom_range(0, 7));
            end else begin
                req_valid = 1'b0;
            end
            tick(1);
        end
        req_valid = 1'b0;
        wait_idle("hold");

        // Reset two cycles after the third address
        do_request(3'd3, 6'd10);
        tick(5);
        rst = 1'b1;
        tick(1);
        check("mid_rst_addr", 32'(rom_word_addr_o), 32'd0);
        check("mid_rst_sel", 32'(rom_sprite_sel_o), 32'd0);
        check("mid_rst_pix_valid", 32'(pix_valid), 32'd0);
        check("mid_rst_pix_o", 32'(pix_o), 32'd0);
        check("mid_rst_pix_last", 32'(pix_last), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        exp_q.delete();
        tick(1);
        rst = 1'b0;
        for (int k = 8; k <= 15; k++) begin
            check("no_stale_write", 32'(pix_valid), 32'd0);
            tick(1);
        end
        do_request(3'd0, 6'd63);
        wait_idle("after_reset");

        // Invalid sprite: zero pixels with normal timing
        row_timing(3'd7, 6'd0);
        wait_idle("invalid");

        // Random ready, 100 back-to-back random requests
        rnd_ready_en = 1'b1;
        last0 = n_last;
        for (int i = 0; i < 100; i++) begin
            do_request(3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)));
        end
        wait_idle("random");
        check("last_count", 32'(n_last - last0), 32'd100);
        rnd_ready_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout reached, required completion");
        $fatal(1, "time limit");
    end

endmodule
